fft_sample_loader: RTL and testbench

Upstream framing stage for the 4-point FFT core.
- Accepts a serial stream of 16-bit samples over a valid/ready handshake and assembles them into 4-sample frames.
- Presents each frame in parallel on `sample0_out`..`sample3_out` and holds `fft_start` high until the core's result is safe to consume.
- Releases `fft_start` for one cycle so the core returns to idle, then accepts the next frame.

---
 rtl/fft_sample_loader.sv | 108 ++++++++++
 tb/tb_fft_sample_loader.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fft_sample_loader.sv
// Frames a serial valid/ready sample stream into 4-sample blocks for the 4-point FFT core.
// Optional build macro LOADER_PRESCALE_EN stores each sample arithmetically shifted right by 2.
module fft_sample_loader #(
    parameter int DATA_W      = 16,
    parameter int FFT_LATENCY = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    output logic [DATA_W-1:0] sample0_out,
    output logic [DATA_W-1:0] sample1_out,
    output logic [DATA_W-1:0] sample2_out,
    output logic [DATA_W-1:0] sample3_out,
    output logic              fft_start,
    input  logic              fft_done,
    output logic              frame_busy,
    output logic              frame_err,
    output logic [7:0]        frame_count
);

    localparam int LAT_W = $clog2(FFT_LATENCY + 1);

    localparam logic [1:0] S_FILL    = 2'd0;
    localparam logic [1:0] S_HOLD    = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;

    logic [1:0]        state;
    logic [1:0]        idx;
    logic [LAT_W-1:0]  lat_cnt;
    logic [DATA_W-1:0] slot [4];
    logic [DATA_W-1:0] stored;
    logic              accept;
    logic              lat_ok;

`ifdef LOADER_PRESCALE_EN
    // Two guard bits against butterfly growth.
    assign stored = DATA_W'($signed(in_data) >>> 2);
`else
    assign stored = in_data;
`endif

    // Gated by reset so the handshake is closed while reset is held.
    assign in_ready   = reset && (state == S_FILL);
    assign fft_start  = (state == S_HOLD);
    assign frame_busy = (state != S_FILL);
    assign accept     = in_valid && in_ready;
    assign lat_ok     = (lat_cnt >= LAT_W'(FFT_LATENCY));

    assign sample0_out = slot[0];
    assign sample1_out = slot[1];
    assign sample2_out = slot[2];
    assign sample3_out = slot[3];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_FILL;
            idx         <= 2'd0;
            lat_cnt     <= '0;
            frame_err   <= 1'b0;
            frame_count <= 8'd0;
            for (int i = 0; i < 4; i++) begin
                slot[i] <= '0;
            end
        end else begin
            frame_err <= 1'b0;
            case (state)
                S_FILL: begin
                    if (accept) begin
                        if (idx == 2'd3) begin
                            slot[idx] <= stored;
                            idx       <= 2'd0;
                            lat_cnt   <= '0;
                            frame_err <= !in_last;
                            state     <= S_HOLD;
                        end else if (in_last) begin
                            // Early last: drop the sample and the partial frame.
                            idx       <= 2'd0;
                            frame_err <= 1'b1;
                        end else begin
                            slot[idx] <= stored;
                            idx       <= idx + 2'd1;
                        end
                    end
                end
                S_HOLD: begin
                    if (!lat_ok) begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                    if (lat_ok && fft_done) begin
                        state <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    frame_count <= frame_count + 8'd1;
                    idx         <= 2'd0;
                    state       <= S_FILL;
                end
                default: begin
                    state <= S_FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_sample_loader.sv
// Directed bench for fft_sample_loader: table of frames plus hand-written
// sequences for early/missing last, stuck done, count wrap and reset in HOLD.
module tb_fft_sample_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [15:0] sample0_out;
    logic [15:0] sample1_out;
    logic [15:0] sample2_out;
    logic [15:0] sample3_out;
    logic        fft_start;
    logic        fft_done;
    logic        frame_busy;
    logic        frame_err;
    logic [7:0]  frame_count;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  exp_count = 8'd0;
    logic        stuck = 1'b0;
    int          dcnt = 0;

    always #5 clk = ~clk;

    fft_sample_loader dut (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_last     (in_last),
        .sample0_out (sample0_out),
        .sample1_out (sample1_out),
        .sample2_out (sample2_out),
        .sample3_out (sample3_out),
        .fft_start   (fft_start),
        .fft_done    (fft_done),
        .frame_busy  (frame_busy),
        .frame_err   (frame_err),
        .frame_count (frame_count)
    );

    // FFT core model: done rises 4 cycles after start, or stuck high.
    always @(posedge clk) begin
        if (!fft_start) dcnt <= 0;
        else if (dcnt < 15) dcnt <= dcnt + 1;
    end
    assign fft_done = stuck | (dcnt >= 4);

    typedef struct packed {
        logic [3:0][15:0] d;
        logic [3:0]       last;
        logic [3:0][15:0] e;
        logic             err;
    } vec_t;

    vec_t tbl [4];

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    task automatic chk_samples(input logic [3:0][15:0] e);
        chk("sample0", 32'(sample0_out), 32'(e[0]));
        chk("sample1", 32'(sample1_out), 32'(e[1]));
        chk("sample2", 32'(sample2_out), 32'(e[2]));
        chk("sample3", 32'(sample3_out), 32'(e[3]));
    endtask

    task automatic run_frame(input vec_t v);
        int n;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i > 0) chk("err_idle", 32'(frame_err), 32'd0);
            chk("ready_fill", 32'(in_ready), 32'd1);
            in_valid = 1'b1;
            in_data  = v.d[i];
            in_last  = v.last[i];
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("err_last", 32'(frame_err), 32'(v.err));
        chk("start_hold", 32'(fft_start), 32'd1);
        chk("busy_hold", 32'(frame_busy), 32'd1);
        chk("ready_hold", 32'(in_ready), 32'd0);
        chk_samples(v.e);
        n = 1;
        while (n < 40) begin
            @(negedge clk);
            if (!fft_start) break;
            n++;
        end
        chk("start_cycles", 32'(n), 32'd5);
        chk("ready_release", 32'(in_ready), 32'd0);
        chk("busy_release", 32'(frame_busy), 32'd1);
        exp_count = exp_count + 8'd1;
        @(negedge clk);
        chk("ready_after", 32'(in_ready), 32'd1);
        chk("busy_after", 32'(frame_busy), 32'd0);
        chk("count", 32'(frame_count), 32'(exp_count));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0].d    = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
        tbl[0].last = 4'b1000;
        tbl[0].e    = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
        tbl[0].err  = 1'b0;
        tbl[1].d    = {16'hFFFF, 16'h0004, 16'h7FFF, 16'h8000};
        tbl[1].last = 4'b1000;
`ifdef LOADER_PRESCALE_EN
        tbl[1].e    = {16'hFFFF, 16'h0001, 16'h1FFF, 16'hE000};
`else
        tbl[1].e    = {16'hFFFF, 16'h0004, 16'h7FFF, 16'h8000};
`endif
        tbl[1].err  = 1'b0;
        tbl[2].d    = {16'h1230, 16'h5670, 16'h9AB0, 16'hDEF0};
        tbl[2].last = 4'b0000;
`ifdef LOADER_PRESCALE_EN
        tbl[2].e    = {16'h048C, 16'h159C, 16'hE6AC, 16'hF7BC};
`else
        tbl[2].e    = {16'h1230, 16'h5670, 16'h9AB0, 16'hDEF0};
`endif
        tbl[2].err  = 1'b1;
        tbl[3].d    = {16'h00C0, 16'h0080, 16'h0040, 16'h0000};
        tbl[3].last = 4'b1000;
`ifdef LOADER_PRESCALE_EN
        tbl[3].e    = {16'h0030, 16'h0020, 16'h0010, 16'h0000};
`else
        tbl[3].e    = {16'h00C0, 16'h0080, 16'h0040, 16'h0000};
`endif
        tbl[3].err  = 1'b0;

        reset    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 16'h0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_start", 32'(fft_start), 32'd0);
        chk("rst_busy", 32'(frame_busy), 32'd0);
        chk("rst_err", 32'(frame_err), 32'd0);
        chk("rst_count", 32'(frame_count), 32'd0);
        chk_samples(64'h0);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(in_ready), 32'd1);
        chk("post_rst_count", 32'(frame_count), 32'd0);

        for (int k = 0; k < 4; k++) run_frame(tbl[k]);

        // Early last on the second sample.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'hAAAA;
        in_last  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_data = 16'hBBBB;
        in_last = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("early_err", 32'(frame_err), 32'd1);
        chk("early_start", 32'(fft_start), 32'd0);
        chk("early_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        chk("early_err_pulse", 32'(frame_err), 32'd0);
        chk("early_start2", 32'(fft_start), 32'd0);
        run_frame(tbl[0]);

        // Stuck done: no shortcut through HOLD.
        stuck = 1'b1;
        run_frame(tbl[3]);
        run_frame(tbl[0]);

        while (exp_count != 8'd255) run_frame(tbl[3]);
        chk("count_255", 32'(frame_count), 32'd255);
        run_frame(tbl[0]);
        chk("count_wrap", 32'(frame_count), 32'd0);
        stuck = 1'b0;

        // Reset during the second HOLD cycle.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = tbl[1].d[i];
            in_last  = tbl[1].last[i];
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("hold1_start", 32'(fft_start), 32'd1);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("async_start", 32'(fft_start), 32'd0);
        chk("async_count", 32'(frame_count), 32'd0);
        chk("async_ready", 32'(in_ready), 32'd0);
        chk("async_busy", 32'(frame_busy), 32'd0);
        @(negedge clk);
        reset     = 1'b1;
        exp_count = 8'd0;
        @(negedge clk);
        chk("rerst_ready", 32'(in_ready), 32'd1);
        chk("rerst_busy", 32'(frame_busy), 32'd0);
        chk_samples(64'h0);
        run_frame(tbl[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
